// File: rtl/match_judge.sv
// Answer-side judge: synchronizes and debounces the player's switches, scores
// rises against the captured target pattern and times the round in BCD seconds.
module match_judge #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIME_LIMIT_S    = 59,
  parameter int unsigned MAX_ERRORS      = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] pattern,
  input  logic [13:0] answer_raw,
  output logic        busy,
  output logic [13:0] remaining,
  output logic [3:0]  err_count,
  output logic        done,
  output logic        win,
  output logic        fail,
  output logic        timeout,
  output logic [3:0]  secs_ones,
  output logic [3:0]  secs_tens
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_SAT  = DW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [3:0]    LIM_T   = 4'(TIME_LIMIT_S / 10);
  localparam logic [3:0]    LIM_O   = 4'(TIME_LIMIT_S % 10);
  localparam logic [4:0]    MAX_E   = 5'(MAX_ERRORS);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_PLAY = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;
  localparam logic [2:0] ST_TOUT = 3'd5;

  logic [2:0]    state;
  logic [13:0]   sync1;
  logic [13:0]   answer_s;
  logic [13:0]   answer_db;
  logic [DW-1:0] db_cnt;
  logic [13:0]   target;
  logic [PW-1:0] presc;

  logic          stable;
  logic          update;
  logic [13:0]   db_next;
  logic [13:0]   miss;
  logic [4:0]    err_sum;
  logic [3:0]    err_next;
  logic          tick;
  logic [3:0]    ones_next;
  logic [3:0]    tens_next;
  logic          fail_hit;
  logic          win_hit;
  logic          tout_hit;
  logic          can_start;

  function automatic logic [4:0] popcount14(input logic [13:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 14; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  // One shared counter: any change of answer_s restarts it; it saturates after acceptance.
  always_comb begin
    stable = (sync1 == answer_s);
    update = stable && (db_cnt == DB_LAST);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1     <= '0;
      answer_s  <= '0;
      db_cnt    <= '0;
      answer_db <= '0;
    end else begin
      sync1    <= answer_raw;
      answer_s <= sync1;
      if (!stable)
        db_cnt <= '0;
      else if (db_cnt < DB_SAT)
        db_cnt <= db_cnt + DW'(1);
      if (update)
        answer_db <= answer_s;
    end
  end

  // End conditions are judged on the post-update answer, error count and time.
  always_comb begin
    db_next   = update ? answer_s : answer_db;
    miss      = update ? (answer_s & ~answer_db & ~target) : '0;
    err_sum   = {1'b0, err_count} + popcount14(miss);
    err_next  = (err_sum > 5'd15) ? 4'hF : err_sum[3:0];
    tick      = (presc == PS_LAST);
    ones_next = secs_ones;
    tens_next = secs_tens;
    if (tick) begin
      if (secs_ones == 4'd9) begin
        ones_next = '0;
        tens_next = secs_tens + 4'd1;
      end else begin
        ones_next = secs_ones + 4'd1;
      end
    end
    fail_hit  = ({1'b0, err_next} >= MAX_E);
    win_hit   = (db_next == target);
    tout_hit  = tick && (tens_next == LIM_T) && (ones_next == LIM_O);
    can_start = start && (pattern != '0) &&
                ((state == ST_IDLE) || (state == ST_WIN) ||
                 (state == ST_FAIL) || (state == ST_TOUT));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      target    <= '0;
      err_count <= '0;
      presc     <= '0;
      secs_ones <= '0;
      secs_tens <= '0;
      done      <= 1'b0;
      win       <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_WIN, ST_FAIL, ST_TOUT: begin
          if (can_start) begin
            state     <= ST_ARM;
            target    <= pattern;
            err_count <= '0;
            presc     <= '0;
            secs_ones <= '0;
            secs_tens <= '0;
            win       <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_ARM: begin
          if (answer_db == '0)
            state <= ST_PLAY;
        end
        ST_PLAY: begin
          presc     <= tick ? '0 : presc + PW'(1);
          secs_ones <= ones_next;
          secs_tens <= tens_next;
          err_count <= err_next;
          if (fail_hit) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
            done  <= 1'b1;
          end else if (win_hit) begin
            state <= ST_WIN;
            win   <= 1'b1;
            done  <= 1'b1;
          end else if (tout_hit) begin
            state   <= ST_TOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_ARM) || (state == ST_PLAY);
    remaining = (state == ST_PLAY) ? (target & ~answer_db) : '0;
  end

endmodule

// File: tb/tb_match_judge.sv
// Scoreboard bench for match_judge: a round-level reference model pushes the
// expected result of every round; a monitor pops it whenever done is seen.
module tb_match_judge;

  localparam int unsigned CLK    = 10;
  localparam int unsigned DB     = 4;
  localparam int unsigned LIMIT  = 5;
  localparam int unsigned MAXERR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] pattern = '0;
  logic [13:0] answer_raw = '0;
  logic        busy, done, win, fail, timeout;
  logic [13:0] remaining;
  logic [3:0]  err_count, secs_ones, secs_tens;

  int checks = 0;
  int errors = 0;

  match_judge #(
    .CLK_HZ(CLK),
    .DEBOUNCE_CYCLES(DB),
    .TIME_LIMIT_S(LIMIT),
    .MAX_ERRORS(MAXERR)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .start(start),
    .pattern(pattern),
    .answer_raw(answer_raw),
    .busy(busy),
    .remaining(remaining),
    .err_count(err_count),
    .done(done),
    .win(win),
    .fail(fail),
    .timeout(timeout),
    .secs_ones(secs_ones),
    .secs_tens(secs_tens)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          f;
    bit          t;
    int unsigned err;
    int unsigned secs;
  } res_t;
  res_t exp_q[$];

  // Reference model. phase: 0 idle, 1 waiting for switches down, 2 playing, 3 over.
  int unsigned m_phase = 0;
  logic [13:0] m_db = '0, m_target = '0, r_last = '0, old_db, rise;
  int unsigned r_run = 2;
  int unsigned m_err = 0, m_play = 0;
  bit          m_win = 0, m_fail = 0, m_tout = 0, m_done = 0;
  res_t        r;

  // A raw value is accepted once it has been sampled DB+1 times in a row.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_db = '0; r_last = '0; r_run = 2; m_target = '0;
      m_err = 0; m_play = 0; m_win = 0; m_fail = 0; m_tout = 0; m_done = 0;
    end else begin
      m_done = 0;
      old_db = m_db;
      rise   = '0;
      if (r_run == DB + 1) begin
        rise = r_last & ~m_db;
        m_db = r_last;
      end
      if (answer_raw == r_last) begin
        if (r_run < 1000) r_run++;
      end else begin
        r_last = answer_raw;
        r_run  = 1;
      end
      case (m_phase)
        0, 3: if (start && pattern != 0) begin
          m_target = pattern; m_err = 0; m_play = 0;
          m_win = 0; m_fail = 0; m_tout = 0; m_phase = 1;
        end
        1: if (old_db == 0) m_phase = 2;
        2: begin
          m_play++;
          m_err = m_err + $countones(rise & ~m_target);
          if (m_err > 15) m_err = 15;
          if (m_err >= MAXERR) m_fail = 1;
          else if (m_db == m_target) m_win = 1;
          else if (m_play == CLK * LIMIT) m_tout = 1;
          if (m_fail || m_win || m_tout) begin
            r.w = m_win; r.f = m_fail; r.t = m_tout;
            r.err = m_err; r.secs = m_play / CLK;
            exp_q.push_back(r);
            m_phase = 3;
            m_done  = 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Monitor: every-cycle output comparison plus result scoreboard on done.
  logic [36:0] exp_vec, act_vec;
  int unsigned secs_m;
  res_t        e;
  always @(negedge clk) begin
    secs_m  = m_play / CLK;
    exp_vec = {(m_phase == 1 || m_phase == 2),
               (m_phase == 2) ? (m_target & ~m_db) : 14'h0,
               4'(m_err), m_done, m_win, m_fail, m_tout,
               4'(secs_m / 10), 4'(secs_m % 10)};
    act_vec = {busy, remaining, err_count, done, win, fail, timeout, secs_tens, secs_ones};
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("FAIL outputs t=%0t got %h expected %h", $time, act_vec, exp_vec);
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result t=%0t unexpected done", $time);
      end else begin
        e = exp_q.pop_front();
        if ({win, fail, timeout} !== {e.w, e.f, e.t} || err_count !== 4'(e.err) ||
            secs_tens !== 4'(e.secs / 10) || secs_ones !== 4'(e.secs % 10)) begin
          errors++;
          $display("FAIL result t=%0t got wft=%b%b%b err=%0d secs=%0d%0d expected wft=%b%b%b err=%0d secs=%0d",
                   $time, win, fail, timeout, err_count, secs_tens, secs_ones,
                   e.w, e.f, e.t, e.err, e.secs);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [13:0] p);
    pattern = p;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while ((m_phase == 1 || m_phase == 2) && k < budget) begin
      cyc(1);
      k++;
    end
    checks++;
    if (m_phase == 1 || m_phase == 2) begin
      errors++;
      $display("FAIL round_end budget %0d expired, busy=%b", budget, busy);
    end
  endtask

  initial begin
    #1;
    cyc(3);
    reset = 1'b0;
    cyc(3);

    do_start(14'h0);
    cyc(4);

    // Win: target bits 0 and 2
    do_start(14'h0005);
    cyc(3);
    answer_raw = 14'h0005;
    wait_end(40);
    answer_raw = '0;
    cyc(8);

    // Fail: one miss, then two simultaneous misses
    do_start(14'h0001);
    cyc(3);
    answer_raw = 14'h0008;
    cyc(8);
    answer_raw = 14'h0038;
    wait_end(40);
    answer_raw = '0;
    cyc(8);

    // Bounce on bit 0, finally held high
    do_start(14'h0001);
    cyc(3);
    for (int i = 0; i < 11; i++) begin
      answer_raw = answer_raw ^ 14'h0001;
      cyc(2);
    end
    wait_end(40);
    answer_raw = '0;
    cyc(8);

    // Timeout with no input
    do_start(14'h0010);
    wait_end(80);

    // Switch up at start holds ARM; then reset in PLAY aborts silently
    answer_raw = 14'h0080;
    cyc(8);
    do_start(14'h0001);
    cyc(15);
    answer_raw = '0;
    cyc(10);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);

    // Randomized rounds
    for (int rd = 0; rd < 20; rd++) begin
      logic [13:0] p;
      answer_raw = '0;
      cyc(8);
      p = 14'($urandom & $urandom);
      if (p == 0) p = 14'(1 << $urandom_range(0, 13));
      do_start(p);
      cyc(2);
      for (int s = 0; s < 30 && (m_phase == 1 || m_phase == 2); s++) begin
        case ($urandom_range(0, 4))
          0: answer_raw = p;
          1, 2: answer_raw = answer_raw ^ 14'(1 << $urandom_range(0, 13));
          3: answer_raw = answer_raw & p;
          default: begin
            pattern = 14'($urandom);
            start   = $urandom_range(0, 1) == 1;
          end
        endcase
        cyc(1);
        start = 1'b0;
        cyc($urandom_range(0, 6));
      end
      wait_end(80);
    end

    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard %0d expected results never presented, 0 required", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
